// File: rtl/mult_rr_sched_pkg.sv
// Shared definitions for the round-robin multiplier scheduler: FSM encoding
// and a width helper for pointer/counter registers.
package mult_rr_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // At least one bit, so a 2-entry index still has a real register.
    function automatic int clog2(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/mult_seq_core.sv
// Sequential shift-add multiplier datapath: loads operands on start, then
// adds one shifted partial product per step for W steps.
module mult_seq_core
    import mult_rr_sched_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_b,
    input  logic           i_start,
    input  logic           i_step,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic [2*W-1:0] o_acc_nxt,
    output logic           o_last
);

    localparam int CW = clog2(W);

    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [2*W-1:0] r_acc;
    logic [CW-1:0]  r_cnt;
    logic [2*W-1:0] w_part;

    assign w_part    = r_b[0] ? ({{W{1'b0}}, r_a} << r_cnt) : '0;
    assign o_acc_nxt = r_acc + w_part;
    assign o_last    = (r_cnt == CW'(W - 1));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_a   <= i_a;
            r_b   <= i_b;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_step) begin
            r_acc <= o_acc_nxt;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mult_rr_sched.sv
// Round-robin arbiter sharing one sequential multiplier among N requesters;
// owns grant, operand capture, sequencing and the done/product return.
module mult_rr_sched
    import mult_rr_sched_pkg::*;
#(
    parameter int W = 4,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_b,
    input  logic [N-1:0]   i_req,
    input  logic [N*W-1:0] i_a_in,
    input  logic [N*W-1:0] i_b_in,
    output logic [N-1:0]   o_gnt,
    output logic [N-1:0]   o_done,
    output logic [2*W-1:0] o_prod,
    output logic           o_busy
);

    localparam int PW = clog2(N);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_win;
    logic [PW-1:0]      w_win;
    logic               w_found;
    logic [N-1:0][W-1:0] w_a;
    logic [N-1:0][W-1:0] w_b;
    logic               w_start;
    logic               w_step;
    logic               w_last;
    logic [2*W-1:0]     w_acc_nxt;

    assign w_a = i_a_in;
    assign w_b = i_b_in;

    // Walk from the far end back toward ptr so the last hit is the first
    // set bit at or after ptr (wrapping).
    always_comb begin
        int idx;
        idx     = 0;
        w_win   = '0;
        w_found = |i_req;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(r_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (i_req[PW'(idx)]) w_win = PW'(idx);
        end
    end

    assign w_start = (r_state == ST_IDLE) && w_found;
    assign w_step  = (r_state == ST_RUN);
    assign o_busy  = (r_state != ST_IDLE);

    mult_seq_core #(.W(W)) u_core (
        .clk       (clk),
        .rst_b     (rst_b),
        .i_start   (w_start),
        .i_step    (w_step),
        .i_a       (w_a[w_win]),
        .i_b       (w_b[w_win]),
        .o_acc_nxt (w_acc_nxt),
        .o_last    (w_last)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_found) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)  w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            o_gnt  <= '0;
            o_done <= '0;
            o_prod <= '0;
            r_ptr  <= '0;
            r_win  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_found) begin
                    o_gnt <= N'(1) << w_win;
                    r_win <= w_win;
                end
                ST_RUN: if (w_last) begin
                    o_prod <= w_acc_nxt;
                    o_done <= o_gnt;
                end
                ST_DONE: begin
                    o_done <= '0;
                    o_gnt  <= '0;
                    r_ptr  <= (r_win == PW'(N - 1)) ? '0 : r_win + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_rr_sched.sv
// Randomised and directed bench for mult_rr_sched against a timeline model
// of each operation (grant, W compute edges, done, release).
module tb_mult_rr_sched;

    localparam int W = 4;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_b;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in, b_in;
    logic [N-1:0]   o_gnt, o_done;
    logic [2*W-1:0] o_prod;
    logic           o_busy;

    logic [1:0]  req6;
    logic [11:0] a6, b6;
    logic [1:0]  gnt6, done6;
    logic [11:0] prod6;
    logic        busy6;

    always #5 clk = ~clk;

    mult_rr_sched #(.W(W), .N(N)) dut (
        .clk(clk), .rst_b(rst_b), .i_req(req), .i_a_in(a_in), .i_b_in(b_in),
        .o_gnt(o_gnt), .o_done(o_done), .o_prod(o_prod), .o_busy(o_busy)
    );

    mult_rr_sched #(.W(6), .N(2)) dut6 (
        .clk(clk), .rst_b(rst_b), .i_req(req6), .i_a_in(a6), .i_b_in(b6),
        .o_gnt(gnt6), .o_done(done6), .o_prod(prod6), .o_busy(busy6)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference: one operation occupies edges age 0 (grant) .. W+1 (release).
    bit m_act;
    int m_age, m_win, m_ptr, m_res, m_prod;
    int rr_exp[5] = '{3, 6, 9, 12, 3};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_act = 0; m_age = 0; m_win = 0; m_ptr = 0; m_res = 0; m_prod = 0;
    endtask

    task automatic model_edge();
        if (rst_b) begin
            if (m_act) begin
                m_age++;
                if (m_age == W) m_prod = m_res;
                if (m_age == W + 1) begin
                    m_act = 0;
                    m_ptr = (m_win + 1) % N;
                end
            end else if (req != 0) begin
                for (int k = 0; k < N; k++) begin
                    int i = (m_ptr + k) % N;
                    if (req[i]) begin
                        m_win = i;
                        break;
                    end
                end
                m_act = 1;
                m_age = 0;
                m_res = int'(a_in[m_win*W +: W]) * int'(b_in[m_win*W +: W]);
            end
        end
    endtask

    task automatic check_all();
        chk("gnt",  32'(o_gnt),  m_act ? (32'd1 << m_win) : 32'd0);
        chk("done", 32'(o_done), (m_act && m_age == W) ? (32'd1 << m_win) : 32'd0);
        chk("prod", 32'(o_prod), 32'(m_prod));
        chk("busy", 32'(o_busy), 32'(m_act));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic reset_pulse();
        rst_b = 1'b0;
        #1;
        model_reset();
        check_all();
        step();
        rst_b = 1'b1;
    endtask

    task automatic wait_idle();
        req = '0;
        for (int i = 0; i < 20 && (o_busy || m_act); i++) step();
        chk("idle", 32'(o_busy), 32'd0);
    endtask

    task automatic run_one(input int lane, input int a, input int b, input int exp);
        int n;
        req = 4'(1 << lane);
        a_in[lane*W +: W] = W'(a);
        b_in[lane*W +: W] = W'(b);
        step();
        chk("one_gnt", 32'(o_gnt), 32'd1 << lane);
        req = '0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            n++;
            if (o_done != 0) break;
        end
        chk("one_lat",  32'(n), 32'(W));
        chk("one_done", 32'(o_done), 32'd1 << lane);
        chk("one_prod", 32'(o_prod), 32'(exp));
        wait_idle();
    endtask

    initial begin
        int k, last, n;
        rst_b = 1'b0;
        req   = 4'hF;
        a_in  = '0;
        b_in  = '0;
        req6  = '0;
        a6    = '0;
        b6    = '0;
        model_reset();
        repeat (3) step();
        rst_b = 1'b1;

        // Round-robin with all requesters held high.
        for (int i = 0; i < N; i++) begin
            a_in[i*W +: W] = W'(i + 1);
            b_in[i*W +: W] = W'(3);
        end
        req = 4'hF;
        k = 0;
        last = 0;
        for (int c = 0; c < 60 && k < 5; c++) begin
            step();
            if (o_done != 0) begin
                chk("rr_done", 32'(o_done), 32'd1 << (k % N));
                chk("rr_prod", 32'(o_prod), 32'(rr_exp[k]));
                if (k > 0) chk("rr_gap", 32'(c - last), 32'd6);
                last = c;
                k++;
            end
        end
        chk("rr_count", 32'(k), 32'd5);
        wait_idle();

        run_one(2, 5, 10, 50);
        run_one(0, 15, 15, 225);
        run_one(3, 0, 9, 0);
        run_one(1, 9, 0, 0);

        // Request withdrawn right after grant; the operation still finishes.
        reset_pulse();
        a_in[1*W +: W] = 4'd7;  b_in[1*W +: W] = 4'd9;
        a_in[2*W +: W] = 4'd2;  b_in[2*W +: W] = 4'd11;
        req = 4'b0110;
        step();
        chk("wd_gnt", 32'(o_gnt), 32'b0010);
        req = 4'b0100;
        for (int i = 0; i < 10 && o_done == 0; i++) step();
        chk("wd_done", 32'(o_done), 32'b0010);
        chk("wd_prod", 32'(o_prod), 32'd63);
        step();
        step();
        chk("wd_next", 32'(o_gnt), 32'b0100);
        wait_idle();

        // Reset two edges into an operation aborts it silently.
        reset_pulse();
        a_in[2*W +: W] = 4'd9;
        b_in[2*W +: W] = 4'd9;
        req = 4'b0100;
        step();
        chk("mr_gnt", 32'(o_gnt), 32'b0100);
        req = '0;
        step();
        step();
        rst_b = 1'b0;
        req = 4'hF;
        #1;
        model_reset();
        check_all();
        repeat (6) step();
        rst_b = 1'b1;
        req = 4'b1000;
        step();
        chk("mr_regnt", 32'(o_gnt), 32'b1000);
        wait_idle();

        // Random traffic with occasional asynchronous resets.
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst_b = 1'b0;
                #1;
                model_reset();
                check_all();
                step();
                rst_b = 1'b1;
            end else begin
                req  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
                a_in = 16'($urandom);
                b_in = 16'($urandom);
                step();
            end
        end
        wait_idle();

        // Wider instance: full-scale operands, latency scales with W.
        req6 = 2'b10;
        a6   = {6'd63, 6'd0};
        b6   = {6'd63, 6'd0};
        step();
        chk("w6_gnt", 32'(gnt6), 32'b10);
        req6 = '0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            n++;
            if (done6 != 0) break;
        end
        chk("w6_lat",  32'(n), 32'd6);
        chk("w6_done", 32'(done6), 32'b10);
        chk("w6_prod", 32'(prod6), 32'd3969);
        step();
        chk("w6_clr", 32'({done6, gnt6}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
